// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_seq_pkg
//  Brief    : Shared types, lane constants and lane helpers for the two-byte
//             memory word sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package mem_seq_pkg;

   // Sequencer states: one request becomes a LO byte access, a HI byte
   // access and a single completion cycle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_FIN  = 2'd3
   } seq_state_t;

   // Logical byte lanes: LO is the access at addr, HI the access at addr+1.
   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   // Values driven on the memory side whenever no byte access is active.
   localparam logic        MEM_EN_OFF   = 1'b0;
   localparam logic        MEM_WR_OFF   = 1'b0;
   localparam logic [15:0] MEM_ADDR_OFF = 16'h0000;
   localparam logic [7:0]  MEM_DATA_OFF = 8'h00;

   // A logical lane maps to the upper word byte when it is HI in
   // little-endian mode, or LO in big-endian mode.
   function automatic logic lane_is_upper(input logic lane, input logic big_endian);
      return lane ^ big_endian;
   endfunction

   // Byte of a word that belongs on the memory bus for a given lane.
   function automatic logic [7:0] lane_extract(input logic [15:0] word,
                                               input logic        lane,
                                               input logic        big_endian);
      return lane_is_upper(lane, big_endian) ? word[15:8] : word[7:0];
   endfunction

   // Word with the byte returned for a given lane merged into its place.
   function automatic logic [15:0] lane_insert(input logic [15:0] word,
                                               input logic [7:0]  bval,
                                               input logic        lane,
                                               input logic        big_endian);
      return lane_is_upper(lane, big_endian) ? {bval, word[7:0]} : {word[15:8], bval};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_word_sequencer
//  Brief    : Turns one 16-bit load/store request into two byte accesses at
//             addr and addr+1 on an 8-bit memory, assembling or splitting the
//             word according to BIG_ENDIAN.
//  Revision : 1.0  initial release
// ============================================================================
module mem_word_sequencer
   import mem_seq_pkg::*;
#(
   parameter logic BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_write,
   input  logic [15:0] i_address,
   input  logic [15:0] i_wdata,
   input  logic [7:0]  i_mem_data_in,
   output logic [15:0] o_mem_addr,
   output logic        o_mem_en,
   output logic        o_mem_wr,
   output logic [7:0]  o_mem_data_out,
   output logic [15:0] o_rdata,
   output logic        o_busy,
   output logic        o_done
);

   seq_state_t  r_state;
   seq_state_t  w_next_state;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   logic        r_wr;
   logic [15:0] r_rdata;
   logic        w_accept;
   logic [15:0] w_addr_hi;

   // A new request is only taken when no byte access is in flight.
   assign w_accept  = i_start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
   // Natural 16-bit truncation makes 0xFFFF wrap to 0x0000.
   assign w_addr_hi = r_addr + 16'd1;

   // State register; reset aborts any transaction immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode: fixed LO -> HI -> FIN walk, FIN may chain a new request.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: w_next_state = w_accept ? ST_LO : ST_IDLE;
         ST_LO:   w_next_state = ST_HI;
         ST_HI:   w_next_state = ST_FIN;
         ST_FIN:  w_next_state = w_accept ? ST_LO : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Request capture and per-lane load assembly; stores leave RData alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= 16'h0000;
         r_wdata <= 16'h0000;
         r_wr    <= 1'b0;
         r_rdata <= 16'h0000;
      end else begin
         if (w_accept) begin
            r_addr  <= i_address;
            r_wdata <= i_wdata;
            r_wr    <= i_write;
         end
         if ((r_state == ST_LO) && !r_wr) begin
            r_rdata <= lane_insert(r_rdata, i_mem_data_in, LANE_LO, BIG_ENDIAN);
         end else if ((r_state == ST_HI) && !r_wr) begin
            r_rdata <= lane_insert(r_rdata, i_mem_data_in, LANE_HI, BIG_ENDIAN);
         end
      end
   end

   // Memory-side outputs, decoded from registered state only (no path from start).
   always_comb begin
      o_mem_en       = MEM_EN_OFF;
      o_mem_wr       = MEM_WR_OFF;
      o_mem_addr     = MEM_ADDR_OFF;
      o_mem_data_out = MEM_DATA_OFF;
      case (r_state)
         ST_LO: begin
            o_mem_en       = 1'b1;
            o_mem_wr       = r_wr;
            o_mem_addr     = r_addr;
            o_mem_data_out = lane_extract(r_wdata, LANE_LO, BIG_ENDIAN);
         end
         ST_HI: begin
            o_mem_en       = 1'b1;
            o_mem_wr       = r_wr;
            o_mem_addr     = w_addr_hi;
            o_mem_data_out = lane_extract(r_wdata, LANE_HI, BIG_ENDIAN);
         end
         default: begin
            o_mem_en       = MEM_EN_OFF;
         end
      endcase
   end

   assign o_rdata = r_rdata;
   assign o_busy  = (r_state == ST_LO) || (r_state == ST_HI);
   assign o_done  = (r_state == ST_FIN);

endmodule
`default_nettype wire

// File: doc/mem_word_sequencer.md
# mem_word_sequencer

Two-byte memory access sequencer sitting between the address register file's memory-address output and the 8-bit-wide data memory. It consumes a 16-bit address (PC, AR or SP as selected upstream) and turns one word request into two byte transactions at addr and addr+1, assembling a 16-bit read word or splitting a 16-bit write word. It is the reader/writer end of the address path: the address register file produces addresses, and this block spends them on memory.

## Interface
- BIG_ENDIAN, default 0: 0 means low byte at addr and high byte at addr+1; 1 swaps the lanes.
- Clock  in  1  single system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; forces IDLE and all reset values immediately.
- Start  in  1  request strobe; sampled only in IDLE or FIN.
- Write  in  1  1 = store word, 0 = load word; latched with Start.
- Address  in  16  word base address; latched with Start.
- WData  in  16  store data; latched with Start.
- MemDataIn  in  8  byte returned by memory; asynchronous read, valid in the same cycle as MemAddr.
- MemAddr  out  16  byte address driven to memory.
- MemEn  out  1  active-high byte-access enable.
- MemWR  out  1  1 = write the byte on the next rising edge; only meaningful while MemEn = 1.
- MemDataOut  out  8  byte to be written.
- RData  out  16  last assembled load word; holds its value until the next load completes.
- Busy  out  1  high in LO and HI.
- Done  out  1  one-cycle pulse in FIN.

## Operation
- States are IDLE, LO, HI and FIN.
- **IDLE:** all memory outputs are inactive.
  - Start = 1 latches Address into addr_q, WData into wdata_q and Write into wr_q, then goes to LO.
- **LO:**
  - MemAddr = addr_q, MemEn = 1, MemWR = wr_q.
  - MemDataOut = low-lane byte of wdata_q.
  - On a load, the clock edge captures MemDataIn into the RData low lane.
  - Next state is HI.
- **HI:**
  - MemAddr = addr_q + 1, truncated to 16 bits, so 0xFFFF wraps to 0x0000.
  - MemDataOut = high-lane byte of wdata_q.
  - On a load, the edge captures MemDataIn into the RData high lane.
  - Next state is FIN.
- **FIN:** Done = 1 and memory outputs are inactive.
  - Start = 1 latches a new request and goes to LO (back-to-back).
  - Otherwise the next state is IDLE.
- Start in LO or HI is ignored and not queued.
- Changes on Address, WData or Write after acceptance have no effect on the transaction in flight.
- A store never modifies RData.
- A load updates each RData lane at its own edge, so RData holds a partially updated word during HI. Consumers use RData only on or after Done.
- Inactive memory outputs are MemEn = 0, MemWR = 0, MemAddr = 0x0000, MemDataOut = 0x00.

## Timing
- Reset values:
  - state = IDLE
  - RData = 0x0000, Busy = 0, Done = 0
  - MemEn = 0, MemWR = 0, MemAddr = 0x0000, MemDataOut = 0x00
- Latency: Start sampled at edge k gives LO in cycle k+1, HI in cycle k+2, and Done in cycle k+3.
- Throughput: one word per 3 cycles with Start held or re-asserted in FIN.
- Memory outputs are decoded from registered state and addr_q, with no combinational path from Start.
- Reset asserted mid-transaction (LO or HI) aborts immediately:
  - MemEn and MemWR drop asynchronously.
  - The partially captured RData is cleared to 0x0000.
  - A store may leave only the low byte written; this is accepted.

## Structure
- Shared package mem_seq_pkg holds:
  - the state enum (IDLE, LO, HI, FIN)
  - the byte-lane select constants LANE_LO and LANE_HI
  - the inactive-value constants for the memory outputs
- Optional sub-module byte_lane_mux: selects the write byte and routes the read byte by lane and BIG_ENDIAN. It is instantiated once for write and once for read.
- Everything else is a single FSM with datapath registers (addr_q, wdata_q, wr_q, RData).

## Test plan
- **Load, little-endian:** memory holds [0x0010]=0x34 and [0x0011]=0x12; Start, Write=0, Address=0x0010 → MemAddr 0x0010 then 0x0011 with MemEn=1 and MemWR=0; Done in cycle k+3; RData=0x1234.
- **Store:** Write=1, Address=0x0020, WData=0xBEEF → byte 0xEF to 0x0020, then 0xBE to 0x0021; RData unchanged.
- **Wrap-around:** load at Address=0xFFFF → second access at MemAddr 0x0000; RData = {mem[0x0000], mem[0xFFFF]}.
- **Back-to-back and ignored Start:** Start held through two transactions → exactly two Done pulses, 3 cycles apart; a Start pulse issued in LO is dropped.
- **Reset in HI:** Reset asserted during HI of a load → MemEn=0 immediately; RData=0x0000; after release the block is in IDLE and Done never fires.
- **BIG_ENDIAN=1:** load with [0x0010]=0x12 and [0x0011]=0x34 → RData=0x1234.
